// File: rtl/cdb_arbiter.sv
// Common data bus producer: per-source holding registers, round-robin grant,
// and a registered one-result-per-cycle broadcast.
package cdb_pkg;
    localparam int ROB_WIDTH = 4;

    typedef struct packed {
        logic                 valid;
        logic [ROB_WIDTH-1:0] tag;
        logic [31:0]          data;
    } cdb_t;
endpackage

module cdb_arbiter #(
    parameter int N_SRC     = 4,
    parameter int ROB_WIDTH = cdb_pkg::ROB_WIDTH
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            flush,
    input  logic [N_SRC-1:0]                src_valid,
    input  logic [N_SRC-1:0][ROB_WIDTH-1:0] src_tag,
    input  logic [N_SRC-1:0][31:0]          src_data,
    output logic [N_SRC-1:0]                src_ready,
    output cdb_pkg::cdb_t                   cdb
);

    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0]                hold_valid_q, hold_valid_d;
    logic [N_SRC-1:0][ROB_WIDTH-1:0] hold_tag_q, hold_tag_d;
    logic [N_SRC-1:0][31:0]          hold_data_q, hold_data_d;
    logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;
    cdb_pkg::cdb_t                   cdb_q, cdb_d;

    logic [N_SRC-1:0] grant;
    logic [N_SRC-1:0] take;
    logic [PTR_W-1:0] gnt_idx;
    logic             any_gnt;
    int               idx;

    // Rotating search starting at rr_ptr; first occupied holding register wins.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        idx     = 0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_SRC;
            if (!any_gnt && hold_valid_q[idx]) begin
                any_gnt      = 1'b1;
                grant[idx]   = 1'b1;
                gnt_idx      = PTR_W'(idx);
            end
        end
    end

    assign src_ready = ~hold_valid_q | grant;
    assign take      = src_valid & src_ready & {N_SRC{~flush}};

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_tag_d   = hold_tag_q;
        hold_data_d  = hold_data_q;
        for (int i = 0; i < N_SRC; i++) begin
            if (flush) begin
                hold_valid_d[i] = 1'b0;
            end else if (take[i]) begin
                hold_valid_d[i] = 1'b1;
                hold_tag_d[i]   = src_tag[i];
                hold_data_d[i]  = src_data[i];
            end else if (grant[i]) begin
                hold_valid_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        cdb_d     = cdb_q;
        cdb_d.valid = 1'b0;
        if (any_gnt && !flush) begin
            rr_ptr_d    = PTR_W'((int'(gnt_idx) + 1) % N_SRC);
            cdb_d.valid = 1'b1;
            cdb_d.tag   = hold_tag_q[gnt_idx];
            cdb_d.data  = hold_data_q[gnt_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            hold_valid_q <= '0;
            hold_tag_q   <= '0;
            hold_data_q  <= '0;
            rr_ptr_q     <= '0;
            cdb_q        <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_tag_q   <= hold_tag_d;
            hold_data_q  <= hold_data_d;
            rr_ptr_q     <= rr_ptr_d;
            cdb_q        <= cdb_d;
        end
    end

    assign cdb = cdb_q;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Producer end of the common data bus. Collects finished results (ROB tag plus 32-bit data) from up to `N_SRC` execution units. Grants at most one result per cycle using round-robin priority, and drives the registered `cdb_t` broadcast that reservation stations and the ROB snoop with `tag_match`. Each source has a one-entry holding register, so a unit can hand off its result and accept new work without waiting for the bus.

## Interface
Parameters:
- `N_SRC`, default 4: number of result sources.
- `ROB_WIDTH`, default package `ROB_WIDTH` (4): tag width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `flush`  in  1  misprediction flush; discards all pending and outgoing results.
- `src_valid`  in  `N_SRC`  source i offers a result.
- `src_tag`  in  `N_SRC` x `ROB_WIDTH`  ROB tag of source i's result.
- `src_data`  in  `N_SRC` x 32  result data of source i.
- `src_ready`  out  `N_SRC`  source i's holding register can accept a result this cycle.
- `cdb`  out  `cdb_t`  registered broadcast: `valid`, `tag`, `data`.

## Operation
- **Per-source state:** `hold_valid[i]`, `hold_tag[i]`, `hold_data[i]`.
- **Handshake:**
  - Source i transfers on a cycle where `src_valid[i] && src_ready[i] && !flush`.
  - `src_ready[i] = !hold_valid[i] || grant[i]`. It is combinational from state and the current grant, and never depends on `src_valid`.
  - A held entry that is granted in the same cycle a new transfer occurs is replaced by the new result (back-to-back throughput of 1 per source per cycle).
- **Arbitration:**
  - `rr_ptr` has width `$clog2(N_SRC)`.
  - Candidates are the sources with `hold_valid` set. Search order is `rr_ptr`, `rr_ptr+1`, … modulo `N_SRC`.
  - The first candidate found gets a one-hot `grant`. At most one grant per cycle. No candidate means no grant.
  - After a grant to source g, `rr_ptr <= (g+1) mod N_SRC`. With no grant, `rr_ptr` holds.
  - Inputs (`src_*`) are never candidates directly; results must pass through the holding register.
- **Broadcast:**
  - On a grant, at the edge: `cdb.valid <= 1`, `cdb.tag <= hold_tag[g]`, `cdb.data <= hold_data[g]`, and `hold_valid[g] <= 0` unless refilled the same cycle.
  - With no grant: `cdb.valid <= 0`. `tag` and `data` keep their old values (don't-care).
- **Flush:**
  - At the edge with `flush=1`: all `hold_valid <= 0` and `cdb.valid <= 0`. Any `src_valid` that cycle is dropped; sources must treat it as not accepted.
  - `src_ready` may still be asserted during flush. Sources discard on flush by protocol.
  - `rr_ptr` is unchanged.
- **Reset:**
  - `rstn=0` at the edge: `hold_valid` all 0, `cdb.valid=0`, `cdb.tag=0`, `cdb.data=0`, `rr_ptr=0`.
  - During reset `src_ready` evaluates to all 1; nothing is captured.
  - Reset has priority over flush and over any transfer.
- **Tag uniqueness:** the ROB guarantees tag uniqueness. The arbiter performs no tag checking.

## Timing
- **Latency:**
  - Result transferred at edge E0 is held in cycle 1.
  - If granted in cycle 1, it appears on `cdb` after edge E1, in cycle 2.
  - Minimum latency is 2 edges; maximum is `N_SRC`+1 edges under full contention.
- **Throughput:** one `cdb.valid` per cycle whenever any holding register is occupied.
- **Starvation bound:** a held entry is granted within `N_SRC` cycles.
- **Stall:** `src_ready[i]` falls only when `hold_valid[i]=1` and another source is granted. It recovers the cycle after source i is granted, or in the same cycle via `grant[i]`.
- **Output duration:** `cdb` is a register output, valid for exactly one cycle per result. No back-pressure from consumers.

## Test plan
- **Reset:** hold `rstn=0` 2 cycles with all `src_valid=1` -> `cdb.valid=0`, `cdb.tag=0`, `cdb.data=0`, `src_ready=4'b1111`. After release with no input, `cdb.valid` stays 0.
- **Single result:** source 2 pushes tag 5, data 0xDEADBEEF at E0 -> `cdb={1,5,0xDEADBEEF}` in cycle 2 only, then `cdb.valid=0`.
- **Full contention:** all 4 sources push (tags 1,2,3,4) at E0 with `rr_ptr=0` -> cdb tags 1,2,3,4 in cycles 2–5. `src_ready[3]=0` during cycles 1–3 while held.
- **Round-robin:** sources 0 and 1 push every cycle continuously -> cdb alternates source 0 / source 1 tags, with neither starved and one valid per cycle.
- **Back-to-back refill:** source 0 alone pushes each cycle with tags 0..7 -> `src_ready[0]` stays 1 and cdb shows tags 0..7 on consecutive cycles.
- **Flush mid-operation:** 3 entries held plus a new push, with `flush=1` for 1 cycle -> next cycle `cdb.valid=0` and all holding registers empty. A subsequent push of tag 9 appears 2 edges later with `rr_ptr` preserved.
